// File: rtl/seq_sub_nibble.sv
// Nibble-serial subtractor: one 4-bit carry-lookahead slice of a - b per cycle, valid/ready on both sides.
// Optional compile-time macro SEQ_SUB_OVF_EN adds the signed-overflow output ovf.
module seq_sub_nibble #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NIBBLES-1:0]   diff,
   output logic                   borrow
`ifdef SEQ_SUB_OVF_EN
   ,
   output logic                   ovf
`endif
);

   localparam int W  = 4 * NIBBLES;
   localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    diff_q, diff_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            carry_q, carry_d;
   logic            borrow_q, borrow_d;
   logic            in_ready_q, in_ready_d;
   logic            out_valid_q, out_valid_d;
`ifdef SEQ_SUB_OVF_EN
   logic            ovf_q, ovf_d;
`endif

   logic [3:0]      a_sl [NIBBLES];
   logic [3:0]      b_sl [NIBBLES];
   logic [4:0]      slice_res;

   // Returns {carry_out, sum} from generate/propagate lookahead.
   function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic cin);
      logic [3:0] g;
      logic [3:0] p;
      logic [4:0] c;
      g    = x & y;
      p    = x ^ y;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin);
      return {c[4], p ^ c[3:0]};
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < NIBBLES; gi++) begin : g_slice
         assign a_sl[gi] = a_q[4*gi +: 4];
         assign b_sl[gi] = b_q[4*gi +: 4];
      end
   endgenerate

   // Subtraction as a + ~b + 1: carry is seeded with 1 on accept.
   assign slice_res = cla4(a_sl[cnt_q], ~b_sl[cnt_q], carry_q);

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      diff_d      = diff_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      borrow_d    = borrow_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
`ifdef SEQ_SUB_OVF_EN
      ovf_d       = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d        = a;
               b_d        = b;
               cnt_d      = '0;
               carry_d    = 1'b1;
               in_ready_d = 1'b0;
               state_d    = RUN;
            end
         end
         RUN: begin
            for (int i = 0; i < NIBBLES; i++) begin
               if (cnt_q == CW'(i)) begin
                  diff_d[4*i +: 4] = slice_res[3:0];
               end
            end
            carry_d = slice_res[4];
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               borrow_d    = ~slice_res[4];
`ifdef SEQ_SUB_OVF_EN
               ovf_d       = (a_q[W-1] ^ b_q[W-1]) & (diff_d[W-1] ^ a_q[W-1]);
`endif
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            // Returning to IDLE first keeps a new accept off this edge.
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         diff_q      <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         borrow_q    <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef SEQ_SUB_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         diff_q      <= diff_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         borrow_q    <= borrow_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
`ifdef SEQ_SUB_OVF_EN
         ovf_q       <= ovf_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign diff      = diff_q;
   assign borrow    = borrow_q;
`ifdef SEQ_SUB_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_seq_sub_nibble.sv
// Directed bench for seq_sub_nibble (NIBBLES=4); ovf checks compile in with SEQ_SUB_OVF_EN.
module tb_seq_sub_nibble;

   localparam int NIBBLES = 4;
   localparam int W = 4 * NIBBLES;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  diff;
   logic          borrow;
`ifdef SEQ_SUB_OVF_EN
   logic          ovf;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   seq_sub_nibble #(.NIBBLES(NIBBLES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow    (borrow)
`ifdef SEQ_SUB_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(output int edges);
      edges = 0;
      while (out_valid !== 1'b1 && edges < 20) begin
         step();
         edges++;
      end
   endtask

   // Full handshake; a/b are scrambled right after the accept edge.
   task automatic do_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] ed, input logic eb, input logic eo);
      int n;
      a = va;
      b = vb;
      in_valid = 1'b1;
      out_ready = 1'b0;
      chk({tag, "_rdy_before"}, 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      a = ~va;
      b = va ^ 16'h5A5A;
      chk({tag, "_busy"}, 32'(in_ready), 32'd0);
      wait_done(n);
      // counting the accepting cycle as cycle 1, out_valid appears in cycle NIBBLES+1
      chk({tag, "_latency"}, 32'(n + 1), 32'(NIBBLES + 1));
      chk({tag, "_diff"}, 32'(diff), 32'(ed));
      chk({tag, "_borrow"}, 32'(borrow), 32'(eb));
`ifdef SEQ_SUB_OVF_EN
      chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
      if (eo === 1'bx) $display("unexpected x flag for %s", tag);
`endif
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
      chk({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
      $display("op %s a=%h b=%h diff=%h borrow=%0d latency=%0d", tag, va, vb, diff, borrow, n + 1);
   endtask

   initial begin
      int n;
      int acc_prev;
      logic [W-1:0] va [3];
      logic [W-1:0] vb [3];
      logic [W-1:0] vd [3];
      logic         vbr [3];

      // Reset state
      step();
      step();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_borrow", 32'(borrow), 32'd0);
`ifdef SEQ_SUB_OVF_EN
      chk("rst_ovf", 32'(ovf), 32'd0);
`endif
      rst_n = 1'b1;
      $display("reset released at cycle %0d", cyc);

      // Accepts on the first edge after release
      do_op("basic", 16'h1234, 16'h0034, 16'h1200, 1'b0, 1'b0);
      do_op("under", 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
      do_op("sgnovf", 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
      do_op("bzero", 16'h5A5A, 16'h0000, 16'h5A5A, 1'b0, 1'b0);
      do_op("negovf", 16'h7000, 16'h9000, 16'hE000, 1'b1, 1'b1);

      // Output held under backpressure
      a = 16'hABCD;
      b = 16'hABCD;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      a = 16'h0F0F;
      wait_done(n);
      chk("hold_seen", 32'(out_valid), 32'd1);
      for (int k = 0; k < 10; k++) begin
         chk("hold_diff", 32'(diff), 32'h0000);
         chk("hold_borrow", 32'(borrow), 32'd0);
         chk("hold_in_ready", 32'(in_ready), 32'd0);
         chk("hold_out_valid", 32'(out_valid), 32'd1);
         step();
      end
      $display("hold ABCD-ABCD diff=%h borrow=%0d after 10 stalled cycles", diff, borrow);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("hold_release", 32'(in_ready), 32'd1);

      // Reset in the middle of RUN
      a = 16'hFFFF;
      b = 16'h1111;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      #2;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_diff", 32'(diff), 32'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         chk("midrst_no_valid", 32'(out_valid), 32'd0);
      end
      $display("mid-run reset: no out_valid in 8 cycles");
      do_op("after_rst", 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0);

      // Back-to-back with in_valid and out_ready held high
      va[0] = 16'hFFFF; vb[0] = 16'h0001; vd[0] = 16'hFFFE; vbr[0] = 1'b0;
      va[1] = 16'h0001; vb[1] = 16'hFFFF; vd[1] = 16'h0002; vbr[1] = 1'b1;
      va[2] = 16'h4321; vb[2] = 16'h1234; vd[2] = 16'h30ED; vbr[2] = 1'b0;
      in_valid = 1'b1;
      out_ready = 1'b1;
      acc_prev = 0;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) begin
            step();
            chk("b2b_idle_rdy", 32'(in_ready), 32'd1);
            chk("b2b_idle_ov", 32'(out_valid), 32'd0);
         end
         a = va[k];
         b = vb[k];
         step();
         if (k > 0) chk("b2b_spacing", 32'(cyc - acc_prev), 32'(NIBBLES + 2));
         acc_prev = cyc;
         wait_done(n);
         chk("b2b_diff", 32'(diff), 32'(vd[k]));
         chk("b2b_borrow", 32'(borrow), 32'(vbr[k]));
         $display("b2b %0d a=%h b=%h diff=%h borrow=%0d accept_cycle=%0d", k, va[k], vb[k], diff, borrow, acc_prev);
      end
      in_valid = 1'b0;
      step();
      out_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/seq_sub_nibble.md
SEQ_SUB_NIBBLE -- requirements
Module: seq_sub_nibble

Interface
REQ-001 Parameter NIBBLES, default 4, SHALL set the number of 4-bit slices; operand width W = 4*NIBBLES.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 in_valid  input  1  SHALL signal that a and b hold a valid request.
REQ-005 in_ready  output  1  SHALL signal that the block accepts a request this cycle.
REQ-006 a  input  W  SHALL be the minuend.
REQ-007 b  input  W  SHALL be the subtrahend.
REQ-008 out_valid  output  1  SHALL signal that diff, borrow (and ovf) are valid.
REQ-009 out_ready  input  1  SHALL signal that the consumer takes the result this cycle.
REQ-010 diff  output  W  SHALL carry a - b modulo 2^W.
REQ-011 borrow  output  1  SHALL be 1 when unsigned a < b.
REQ-012 ovf  output  1  SHALL be the signed overflow flag; present only per REQ-030.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 IDLE with in_valid=1 SHALL register a and b, clear the slice counter, set the internal carry to 1 and go to RUN.
REQ-016 Each RUN cycle SHALL compute slice k as a[k] + ~b[k] + carry using 4-bit carry-lookahead logic (generate/propagate), write diff[4k+3:4k], update carry and increment k.
REQ-017 RUN SHALL go to DONE on the edge that writes slice NIBBLES-1; out_valid SHALL therefore first be high NIBBLES+1 cycles after the accepting edge (5 cycles for NIBBLES=4).
REQ-018 In DONE, borrow SHALL equal the inverse of the final slice carry.
REQ-019 diff, borrow and ovf SHALL remain stable while out_valid=1 and out_ready=0.
REQ-020 DONE with out_ready=1 SHALL go to IDLE; a new request SHALL not be accepted on that same edge.
REQ-021 Changes on a or b after acceptance SHALL not affect the in-flight result.
REQ-022 in_valid while not in IDLE SHALL be ignored; the request is taken when IDLE is reached and in_valid is still high.
REQ-023 diff bits for slices not yet written during RUN SHALL retain their previous value and are not observable as valid.
REQ-024 a == b SHALL yield diff=0, borrow=0; b=0 SHALL yield diff=a, borrow=0.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, in_ready=1 after release, out_valid=0, diff=0, borrow=0, ovf=0, counter=0, carry=0.
REQ-026 Reset asserted in RUN or DONE SHALL discard the in-flight operation with no out_valid pulse.
REQ-027 The first rising edge after rst_n deasserts SHALL be able to accept a request.

Configuration
REQ-028 Macro SEQ_SUB_OVF_EN SHALL be the only compile-time option.
REQ-029 Without SEQ_SUB_OVF_EN, port ovf and its logic SHALL not exist.
REQ-030 With SEQ_SUB_OVF_EN, ovf SHALL be 1 in DONE when a[W-1] != b[W-1] and diff[W-1] != a[W-1], else 0.

Verification
REQ-031 a=0x1234, b=0x0034 -> diff=0x1200, borrow=0, out_valid 5 cycles after accept.
REQ-032 a=0x0000, b=0x0001 -> diff=0xFFFF, borrow=1; with macro, ovf=0.
REQ-033 With SEQ_SUB_OVF_EN: a=0x8000, b=0x0001 -> diff=0x7FFF, borrow=0, ovf=1.
REQ-034 a=0xABCD, b=0xABCD, out_ready held 0 for 10 cycles -> diff=0x0000, borrow=0 stable, in_ready=0 throughout.
REQ-035 rst_n pulsed low during cycle 2 of RUN -> out_valid never asserts; next request a=0x0005, b=0x0003 -> diff=0x0002.
REQ-036 Back-to-back in_valid=1 with out_ready=1 -> accepts spaced NIBBLES+2 cycles apart, each result correct.
